ls_data_responder: RTL

// - Responder (memory-side end) of the load/store sub-unit request interface driven by the

---
 rtl/ls_data_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ls_data_responder.sv
// ls_data_responder: memory-side responder for the LSU sub-unit request bus.
// Byte-enabled stores, fixed-latency in-order loads, bounded outstanding count.
//
// Parameters:
//   DEPTH_WORDS      words in the array (power of two, >=16, <=2^29)
//   READ_LATENCY     accept-to-data_valid cycles for loads (1..4)
//   MAX_OUTSTANDING  loads accepted but not yet returned (1..READ_LATENCY)
//   BASE_ADDR        byte address of word 0, aligned to 4*DEPTH_WORDS
// Ports:
//   clk, rst_n       clock, async active-low reset
//   new_request      request strobe, taken only with ready=1
//   addr             byte address, [1:0] ignored
//   load, store      request kind; both set means store
//   be, data_in      store byte enables and data
//   ready            request can be accepted this cycle
//   data_valid       one-cycle pulse with a load result on data_out
//   data_out         load word; holds last result between pulses
//   busy             one or more loads outstanding
//   error            (LS_RESP_ERR_EN only) out-of-range load result
// Build option LS_RESP_ERR_EN: range-check against BASE_ADDR and add
// the error port. Without it all addresses wrap modulo the array size.

module ls_data_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_request,
  input  logic [31:0] addr,
  input  logic        load,
  input  logic        store,
  input  logic [3:0]  be,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        data_valid,
  output logic [31:0] data_out,
  output logic        busy
`ifdef LS_RESP_ERR_EN
  ,
  output logic        error
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int LAST = int'(READ_LATENCY) - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LOAD,
    REQ_STORE
  } req_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] dat;
  } rd_slot_t;

  req_e          req_kind;
  logic          accept;
  logic          ld_acc;
  logic          st_acc;
  logic          st_wr;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [CW-1:0] cnt;
  logic          unused_off;

  logic [31:0] mem [DEPTH_WORDS];
  rd_slot_t    pipe     [READ_LATENCY];
  rd_slot_t    stage_in [READ_LATENCY];

  // store wins when both kind bits are set
  always_comb begin
    req_kind = REQ_NONE;
    unique case (1'b1)
      store:          req_kind = REQ_STORE;
      load && !store: req_kind = REQ_LOAD;
      default:        req_kind = REQ_NONE;
    endcase
  end

  assign accept = new_request && ready
                  && (req_kind != REQ_NONE);
  assign ld_acc = accept && (req_kind == REQ_LOAD);
  assign st_acc = accept && (req_kind == REQ_STORE);

  // BASE_ADDR is size-aligned, so the offset's
  // word bits equal the raw address word bits
  assign off = addr - BASE_ADDR;
  assign idx = off[2 +: AW];

`ifdef LS_RESP_ERR_EN
  assign in_range = (off[31:AW+2] == '0);
`else
  assign in_range = 1'b1;
`endif

  assign unused_off = ^{off[1:0], off[31:AW+2]};

  assign st_wr   = st_acc && in_range;
  assign rd_word = mem[idx];
  assign ld_data = in_range ? rd_word : 32'h0;

  // array is deliberately not reset
  always_ff @(posedge clk) begin
    if (st_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    stage_in[0] = {ld_acc, ld_data};
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_in[i] = pipe[i-1];
    end
  end

  // last slot doubles as the output register:
  // its data only moves when a result lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        if (i != LAST || stage_in[i].vld) begin
          pipe[i] <= stage_in[i];
        end else begin
          pipe[i].vld <= 1'b0;
        end
      end
    end
  end

  assign data_valid = pipe[LAST].vld;
  assign data_out   = pipe[LAST].dat;

`ifdef LS_RESP_ERR_EN
  logic [READ_LATENCY-1:0] perr;

  // error flag shifts in lockstep with the valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= '0;
    end else begin
      perr[0] <= ld_acc && !in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        perr[i] <= perr[i-1];
      end
    end
  end

  assign error = data_valid && perr[LAST];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({ld_acc, data_valid})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // a slot retiring this cycle may be refilled
  assign ready = (cnt < CNT_MAX) || data_valid;
  assign busy  = (cnt != '0);

`ifndef SYNTHESIS
  a_cnt_max : assert property (
    @(posedge clk) disable iff (!rst_n)
    cnt <= CNT_MAX);

  a_cnt_underflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(data_valid && cnt == '0));

  a_req_not_ready : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(new_request && !ready))
    else $warning("ls_data_responder: request while not ready ignored");
`endif

endmodule
